// File: rtl/heartbeat_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nesoi_pkg : shared heartbeat types and default parameter values          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package nesoi_pkg;

  localparam int HB_TAP_DEF      = 18;
  localparam int HB_CHANNELS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } hb_state_t;

endpackage
`default_nettype wire

// File: rtl/heartbeat_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heartbeat_monitor_if : liveness inputs, fault flags and LED outputs      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface heartbeat_monitor_if
  import nesoi_pkg::*;
#(
  parameter int CHANNELS = HB_CHANNELS_DEF
);

  logic [CHANNELS-1:0] alive;
  logic                fault_clr;
  logic [CHANNELS-1:0] fault;
  logic                tick;
  logic                led_ok;
  logic                led_fault;

  modport master (
    output alive, fault_clr,
    input  fault, tick, led_ok, led_fault
  );

  modport slave (
    input  alive, fault_clr,
    output fault, tick, led_ok, led_fault
  );

endinterface
`default_nettype wire

// File: rtl/heartbeat_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heartbeat_watchdog : one-channel tick watchdog with sticky fault flag    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module heartbeat_watchdog
  import nesoi_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic alive_i,
  input  logic clr_i,
  output logic fault_o
);

  localparam int              WD_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_TICKS);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            fault_q, fault_d;

  // The fault flag looks at the next count so it rises on the timeout edge itself.
  always_comb begin
    wd_d = wd_q;
    if (clr_i || alive_i) begin
      wd_d = '0;
    end else if (tick_i && (wd_q < WD_MAX)) begin
      wd_d = wd_q + WD_W'(1);
    end
    fault_d = clr_i ? 1'b0 : (fault_q | (wd_d == WD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;

endmodule
`default_nettype wire

// File: rtl/heartbeat_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heartbeat_monitor : prescaler, heartbeat LED, per-channel watchdogs and  |
// | fault LED (blink code when HEARTBEAT_BLINK_CODE_EN is defined). Rev 1.0  |
// +--------------------------------------------------------------------------+
module heartbeat_monitor
  import nesoi_pkg::*;
#(
  parameter int CHANNELS      = HB_CHANNELS_DEF,
  parameter int TAP           = HB_TAP_DEF,
  parameter int TIMEOUT_TICKS = 8,
  parameter int GAP_TICKS     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  heartbeat_monitor_if.slave bus
);

  // Registering tick one count early keeps it aligned with the all-ones count.
  localparam logic [TAP-1:0] CNT_PRE = ~TAP'(1);

  logic [TAP-1:0]      cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                led_ok_q, led_ok_d;
  logic                led_fault_q, led_fault_d;
  logic [CHANNELS-1:0] fault_vec;

  always_comb begin
    cnt_d    = cnt_q + TAP'(1);
    tick_d   = (cnt_q == CNT_PRE);
    led_ok_d = led_ok_q;
    if (|fault_vec) begin
      led_ok_d = 1'b0;
    end else if (tick_q) begin
      led_ok_d = ~led_ok_q;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_wd
    heartbeat_watchdog #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_wd (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick_q),
      .alive_i(bus.alive[c]),
      .clr_i  (bus.fault_clr),
      .fault_o(fault_vec[c])
    );
  end

`ifdef HEARTBEAT_BLINK_CODE_EN
  localparam int CODE_W = $clog2(CHANNELS + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);

  hb_state_t         state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, low_code;
  logic [GAP_W-1:0]  gap_q, gap_d;

  // Scan from the top so the lowest faulted channel wins.
  always_comb begin
    low_code = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (fault_vec[c]) low_code = CODE_W'(c + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (tick_q && (|fault_vec)) begin
        code_d  = low_code;
        state_d = ON;
      end
      ON: if (tick_q) begin
        code_d  = code_q - CODE_W'(1);
        state_d = OFF;
      end
      OFF: if (tick_q) begin
        if (code_q == '0) begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_TICKS);
        end else begin
          state_d = ON;
        end
      end
      GAP: if (tick_q) begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.fault_clr) state_d = IDLE;
    led_fault_d = (state_d == ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      gap_q   <= gap_d;
    end
  end
`else
  always_comb begin
    led_fault_d = |fault_vec;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      led_ok_q    <= 1'b0;
      led_fault_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      led_ok_q    <= led_ok_d;
      led_fault_q <= led_fault_d;
    end
  end

  assign bus.fault     = fault_vec;
  assign bus.tick      = tick_q;
  assign bus.led_ok    = led_ok_q;
  assign bus.led_fault = led_fault_q;

endmodule
`default_nettype wire
